piso_buffered: RTL and testbench

- Width-down converter: accepts wide words over a valid/ready handshake and emits them as DATA_OUT_WIDTH slices, least-significant slice first, over a second valid/ready handshake.
- Sits downstream of the serial-in/parallel-out packer. A word packed LSB-first and unpacked here comes back out in its original slice order.
- Double-buffered: one active shift register plus one pending holding register. This gives sustained, bubble-free output at one slice per cycle.

---
 rtl/piso_buffered.sv | 116 +++++++++++
 tb/tb_piso_buffered.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_buffered.sv
// piso_buffered: wide-to-narrow width converter. It accepts wide words over a
// valid/ready handshake and emits them least-significant slice first. An active
// shift register and a pending holding register keep the output bubble-free.
module piso_buffered #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      empty
);

  localparam int NUM_SHIFTS  = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int COUNT_WIDTH = $clog2(NUM_SHIFTS) + 1;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(NUM_SHIFTS);

  // Reject parameter sets where the wide word is not a whole number of slices.
  if ((DATA_OUT_WIDTH < 1) || (DATA_IN_WIDTH < DATA_OUT_WIDTH) ||
      ((DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0)) begin : g_bad_params
    $error("piso_buffered: DATA_IN_WIDTH must be a multiple of DATA_OUT_WIDTH");
  end

  // Active word being shifted out, and the word waiting behind it.
  logic [DATA_IN_WIDTH-1:0] shift_r;
  logic [COUNT_WIDTH-1:0]   remaining_r;
  logic [DATA_IN_WIDTH-1:0] pend_r;
  logic                     pend_valid_r;
  logic                     in_ready_r;

  logic [DATA_IN_WIDTH-1:0] shift_nxt_s;
  logic [COUNT_WIDTH-1:0]   remaining_nxt_s;
  logic [DATA_IN_WIDTH-1:0] pend_nxt_s;
  logic                     pend_valid_nxt_s;

  logic out_fire_s;
  logic in_fire_s;
  logic active_free_s;

  // Output decode comes straight from registers; out_ready never reaches it.
  assign out_valid = (remaining_r != CNT_ZERO);
  assign out_last  = (remaining_r == CNT_ONE);
  assign data_out  = shift_r[DATA_OUT_WIDTH-1:0];
  assign empty     = (remaining_r == CNT_ZERO) && !pend_valid_r;

  // Ready is a flop mirroring !pend_valid; reset masks it so nothing is taken.
  assign in_ready  = in_ready_r && !reset;

  assign out_fire_s    = out_valid && out_ready;
  assign in_fire_s     = in_valid && in_ready;
  assign active_free_s = (remaining_r == CNT_ZERO) ||
                         ((remaining_r == CNT_ONE) && out_fire_s);

  // Next-state for the active/pending pair: pending word wins the free slot.
  always_comb begin
    shift_nxt_s      = shift_r;
    remaining_nxt_s  = remaining_r;
    pend_nxt_s       = pend_r;
    pend_valid_nxt_s = pend_valid_r;
    if (active_free_s) begin
      if (pend_valid_r) begin
        // in_ready is low here, so no new word can collide with this move
        shift_nxt_s      = pend_r;
        remaining_nxt_s  = CNT_FULL;
        pend_valid_nxt_s = 1'b0;
      end else if (in_fire_s) begin
        shift_nxt_s     = data_in;
        remaining_nxt_s = CNT_FULL;
      end else begin
        remaining_nxt_s = CNT_ZERO;
      end
    end else begin
      if (out_fire_s) begin
        shift_nxt_s     = shift_r >> DATA_OUT_WIDTH;
        remaining_nxt_s = remaining_r - CNT_ONE;
      end else begin
        shift_nxt_s     = shift_r;
        remaining_nxt_s = remaining_r;
      end
      if (in_fire_s) begin
        pend_nxt_s       = data_in;
        pend_valid_nxt_s = 1'b1;
      end else begin
        pend_nxt_s       = pend_r;
        pend_valid_nxt_s = pend_valid_r;
      end
    end
  end

  // State registers with synchronous reset; reset drops both held words.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r      <= {DATA_IN_WIDTH{1'b0}};
      remaining_r  <= CNT_ZERO;
      pend_r       <= {DATA_IN_WIDTH{1'b0}};
      pend_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      shift_r      <= shift_nxt_s;
      remaining_r  <= remaining_nxt_s;
      pend_r       <= pend_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      in_ready_r   <= !pend_valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_piso_buffered.sv
// tb_piso_buffered: directed bench for piso_buffered at the default 64->16
// configuration and at the degenerate 16->16 configuration.
module tb_piso_buffered;

  localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W2 = 64'h8888_7777_6666_5555;
  localparam logic [63:0] W3 = 64'hCCCC_BBBB_AAAA_9999;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        empty;

  logic [15:0] data_in1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] data_out1;
  logic        out_valid1;
  logic        out_ready1;
  logic        out_last1;
  logic        empty1;

  int checks = 0;
  int errors = 0;

  piso_buffered #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .empty(empty)
  );

  piso_buffered #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in1), .in_valid(in_valid1),
    .in_ready(in_ready1), .data_out(data_out1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1), .empty(empty1)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = 64'h0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; data_in1 = 16'h0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b expected 0", out_last); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset data_out: got %h expected 0000", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %b expected 1", empty); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready_during: got %b expected 0", in_ready); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL reset empty1: got %b expected 1", empty1); end
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready_after: got %b expected 1", in_ready); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset in_ready1_after: got %b expected 1", in_ready1); end
  endtask

  task automatic test_single();
    logic [15:0] exp_d [4];
    exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    out_ready = 1'b1; data_in = W1; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single in_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single out_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL single data[%0d]: got %h expected %h", i, data_out, exp_d[i]); end
      checks++; if (out_last !== ((i == 3) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL single last[%0d]: got %b", i, out_last); end
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single empty: got %b expected 1", empty); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [8];
    logic        exp_r [8];
    exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1; data_in = W1; in_valid = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b bubble[%0d]: out_valid %b expected 1", i, out_valid); end
      checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL b2b data[%0d]: got %h expected %h", i, data_out, exp_d[i]); end
      checks++; if (out_last !== ((i == 3 || i == 7) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL b2b last[%0d]: got %b", i, out_last); end
      checks++; if (in_ready !== exp_r[i]) begin errors++; $display("FAIL b2b in_ready[%0d]: got %b expected %b", i, in_ready, exp_r[i]); end
      if (i == 0) data_in = W2;
      else if (i == 1) in_valid = 1'b0;
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b empty: got %b expected 1", empty); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d [14];
    logic        exp_l [14];
    logic        exp_r [14];
    logic        drv_o [14];
    logic        drv_v [14];
    exp_d = '{16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
              16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    drv_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    drv_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1; data_in = W1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== 16'h1111) begin errors++; $display("FAIL bp first: got %h expected 1111", data_out); end
    step();
    for (int k = 0; k < 14; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (data_out !== exp_d[k]) begin errors++; $display("FAIL bp data[%0d]: got %h expected %h", k, data_out, exp_d[k]); end
      checks++; if (out_last !== exp_l[k]) begin errors++; $display("FAIL bp last[%0d]: got %b expected %b", k, out_last, exp_l[k]); end
      checks++; if (in_ready !== exp_r[k]) begin errors++; $display("FAIL bp in_ready[%0d]: got %b expected %b", k, in_ready, exp_r[k]); end
      out_ready = drv_o[k];
      in_valid  = drv_v[k];
      data_in   = (k == 0) ? W2 : W3;
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp empty: got %b expected 1", empty); end
  endtask

  task automatic test_simul_free_load();
    logic [15:0] exp_d [8];
    exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    out_ready = 1'b1; data_in = W1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL sfl data[%0d]: got %h expected %h", i, data_out, exp_d[i]); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sfl out_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sfl pend_free[%0d]: in_ready %b expected 1", i, in_ready); end
      in_valid = (i == 3) ? 1'b1 : 1'b0;
      data_in  = W2;
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sfl empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; data_in = W1; in_valid = 1'b1;
    step();
    data_in = W2;
    step();
    checks++; if (data_out !== 16'h2222) begin errors++; $display("FAIL rst_mid pre: got %h expected 2222", data_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid pend_held: in_ready %b expected 0", in_ready); end
    reset = 1'b1; data_in = W3; in_valid = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid: got %b expected 0", out_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid empty: got %b expected 1", empty); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid in_ready: got %b expected 0", in_ready); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL rst_mid data_out: got %h expected 0000", data_out); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready_after: got %b expected 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid stale[%0d]: out_valid %b data %h", i, out_valid, data_out); end
    end
  endtask

  task automatic test_num1();
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    out_ready1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in1  = 16'hA000 + 16'(i);
      in_valid1 = 1'b1;
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL n1 in_ready[%0d]: got %b expected 1", i, in_ready1); end
      step();
      checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL n1 out_valid[%0d]: got %b expected 1", i, out_valid1); end
      checks++; if (data_out1 !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL n1 data[%0d]: got %h expected %h", i, data_out1, 16'hA000 + 16'(i)); end
      checks++; if (out_last1 !== 1'b1) begin errors++; $display("FAIL n1 last[%0d]: got %b expected 1", i, out_last1); end
    end
    in_valid1 = 1'b0;
    step();
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL n1 empty: got %b expected 1", empty1); end
    // random consumer stalls against an in-order reference queue
    while (got < 16 && cyc < 400) begin
      in_valid1  = (sent < 16) ? 1'b1 : 1'b0;
      data_in1   = 16'hA100 + 16'(sent);
      out_ready1 = 1'($urandom_range(0, 1));
      #1;
      if (in_valid1 && in_ready1) begin
        exp_q.push_back(data_in1);
        sent++;
      end
      if (out_valid1 && out_ready1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL n1 rand_dup: got %h expected nothing", data_out1);
        end else begin
          exp_v = exp_q.pop_front();
          checks++; if (data_out1 !== exp_v) begin errors++; $display("FAIL n1 rand_data: got %h expected %h", data_out1, exp_v); end
          checks++; if (out_last1 !== 1'b1) begin errors++; $display("FAIL n1 rand_last: got %b expected 1", out_last1); end
        end
        got++;
      end
      step();
      cyc++;
    end
    in_valid1 = 1'b0;
    checks++; if (got != 16) begin errors++; $display("FAIL n1 rand_count: got %0d expected 16", got); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL n1 rand_empty: got %b expected 1", empty1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simul_free_load();
    test_reset_mid();
    test_num1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
